demux4_deserializer: RTL

Sequential 1-to-4 demultiplexer that is the receive end of the time-multiplexed lane link driven by our 4:1 select tree. The transmit side scans four lanes onto one serial bit per cycle. This block routes each incoming bit to its lane slot, reassembles the 4-bit word and presents it atomically with a one-cycle valid strobe. It sits between the serial link input and the board-level LEDR/display logic.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux4_deserializer_slot_counter.sv | 25 ++
 rtl/demux4_deserializer.sv | 107 ++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and defaults for the lane-link deserializer.
package demux_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int N_LANES_DEFAULT = 4;

endpackage

// File: rtl/demux4_deserializer_slot_counter.sv
// Lane slot counter: clear has priority over load-to-1, which has priority over increment.
module slot_counter #(
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [SEL_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= SEL_W'(1);
    end else if (inc) begin
      count <= count + SEL_W'(1);
    end
  end

endmodule

// File: rtl/demux4_deserializer.sv
// Receive end of the time-multiplexed lane link: reassembles N serial bits into one word.
//   state   | meaning
//   HUNT    | idle, waiting for a sync-marked bit to start a word
//   COLLECT | lane 0 taken, filling lanes 1..N-1; an early sync restarts the word
module demux4_deserializer
  import demux_pkg::*;
#(
  parameter int N     = N_LANES_DEFAULT,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [N-1:0]     q,
  output logic             q_valid,
  output logic [SEL_W-1:0] slot,
  output logic             resync_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);

  state_t         state, state_nxt;
  logic [N-1:0]   stage, stage_nxt;
  logic [N-1:0]   q_nxt;
  logic           q_valid_nxt;
  logic           resync_err_nxt;
  logic           cnt_clr, cnt_load1, cnt_inc;

  slot_counter #(
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .count (slot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      stage      <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      stage      <= stage_nxt;
      q          <= q_nxt;
      q_valid    <= q_valid_nxt;
      resync_err <= resync_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    stage_nxt      = stage;
    q_nxt          = q;
    q_valid_nxt    = 1'b0;
    resync_err_nxt = 1'b0;
    cnt_clr        = 1'b0;
    cnt_load1      = 1'b0;
    cnt_inc        = 1'b0;

    case (state)
      HUNT: begin
        if (din_valid && sync) begin
          stage_nxt    = '0;
          stage_nxt[0] = din;
          cnt_load1    = 1'b1;
          state_nxt    = COLLECT;
        end
      end

      COLLECT: begin
        if (din_valid) begin
          if (sync) begin
            // Early sync: drop the partial word and treat this bit as a fresh lane 0.
            resync_err_nxt = 1'b1;
            stage_nxt      = '0;
            stage_nxt[0]   = din;
            cnt_load1      = 1'b1;
          end else begin
            stage_nxt[slot] = din;
            if (slot == LAST_SLOT) begin
              q_nxt       = stage_nxt;
              q_valid_nxt = 1'b1;
              cnt_clr     = 1'b1;
              state_nxt   = HUNT;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end

      default: begin
        state_nxt = HUNT;
        cnt_clr   = 1'b1;
      end
    endcase
  end

endmodule
